// File: rtl/elastic_fifo_mem.sv
// Token storage for elastic_fifo: one synchronous write port and one asynchronous read port.
// Contents are never reset; the control logic only reads slots it has written.
module elastic_fifo_mem #(
    parameter int NUM_SLOTS = 4,
    parameter int DATA_TYPE = 32,
    parameter int PTR_W     = 2
) (
    input  logic                 clk,
    input  logic                 wr_en_i,
    input  logic [PTR_W-1:0]     wr_addr_i,
    input  logic [DATA_TYPE-1:0] wr_data_i,
    input  logic [PTR_W-1:0]     rd_addr_i,
    output logic [DATA_TYPE-1:0] rd_data_o
);
    logic [DATA_TYPE-1:0] mem_q [NUM_SLOTS];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];
endmodule

// File: rtl/elastic_fifo.sv
// Elastic FIFO with registered handshakes and one-cycle latency: ready/valid derive
// only from the occupancy register, so there is no combinational path across the queue.
module elastic_fifo #(
    parameter int NUM_SLOTS = 4,
    parameter int DATA_TYPE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_TYPE-1:0] ins,
    input  logic                 ins_valid,
    output logic                 ins_ready,
    output logic [DATA_TYPE-1:0] outs,
    output logic                 outs_valid,
    input  logic                 outs_ready
);
    localparam int PTR_W = $clog2(NUM_SLOTS);
    localparam int CNT_W = $clog2(NUM_SLOTS + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_SLOTS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_SLOTS);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_en;
    logic             rd_en;

    assign ins_ready  = (count_q != CNT_FULL);
    assign outs_valid = (count_q != '0);
    assign wr_en      = ins_valid & ins_ready;
    assign rd_en      = outs_valid & outs_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers wrap explicitly so non-power-of-two depths work.
        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    elastic_fifo_mem #(
        .NUM_SLOTS (NUM_SLOTS),
        .DATA_TYPE (DATA_TYPE),
        .PTR_W     (PTR_W)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (ins),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (outs)
    );
endmodule

// File: tb/tb_elastic_fifo.sv
// Bench for elastic_fifo: five instances of different depths driven one at a time,
// checked against a queue-based occupancy/order model.
module tb_elastic_fifo;
    localparam int NI = 5;

    function automatic int ns_of(input int g);
        case (g)
            0:       return 4;
            1:       return 3;
            2:       return 2;
            3:       return 5;
            default: return 8;
        endcase
    endfunction

    logic        clk;
    logic        rst;
    logic [31:0] ins        [NI];
    logic        ins_valid  [NI];
    logic        ins_ready  [NI];
    logic [31:0] outs       [NI];
    logic        outs_valid [NI];
    logic        outs_ready [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        elastic_fifo #(
            .NUM_SLOTS (ns_of(g)),
            .DATA_TYPE (32)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .ins        (ins[g]),
            .ins_valid  (ins_valid[g]),
            .ins_ready  (ins_ready[g]),
            .outs       (outs[g]),
            .outs_valid (outs_valid[g]),
            .outs_ready (outs_ready[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] mq[$];
    bit          last_wr;
    bit          last_rd;

    // Advance one clock on instance k, updating the reference queue from the
    // handshake rules; returns at posedge+1.
    task automatic step(input int k);
        bit          wr;
        bit          rd;
        logic [31:0] d;
        wr = (ins_valid[k] === 1'b1) && (mq.size() != ns_of(k));
        rd = (outs_ready[k] === 1'b1) && (mq.size() != 0);
        d  = ins[k];
        @(posedge clk);
        if (rd) void'(mq.pop_front());
        if (wr) mq.push_back(d);
        last_wr = wr;
        last_rd = rd;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        mq.delete();
    endtask

    task automatic test_reset();
        ins_valid[0]  = 1'b1;
        ins[0]        = 32'hDEAD_BEEF;
        outs_ready[0] = 1'b0;
        rst           = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (outs_valid[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_outs_valid cyc %0d: got %b expected 0", c, outs_valid[0]);
            end
            vectors++;
            if (ins_ready[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_ins_ready cyc %0d: got %b expected 1", c, ins_ready[0]);
            end
        end
        ins_valid[0] = 1'b0;
        rst          = 1'b1;
        mq.delete();
        @(posedge clk);
        #1;
        vectors++;
        if (outs_valid[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_no_write: outs_valid got %b expected 0", outs_valid[0]);
        end
        ins[0]       = 32'h0000_00A5;
        ins_valid[0] = 1'b1;
        vectors++;
        if (outs_valid[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_no_bypass: outs_valid got %b expected 0", outs_valid[0]);
        end
        step(0);
        ins_valid[0] = 1'b0;
        vectors++;
        if (outs_valid[0] !== 1'b1 || outs[0] !== 32'hA5) begin
            miscompares++;
            $display("FAIL first_after_reset: got vld=%b data=%h expected vld=1 data=a5",
                     outs_valid[0], outs[0]);
        end
    endtask

    task automatic test_fill();
        logic [31:0] got[$];
        do_reset();
        outs_ready[0] = 1'b0;
        for (int v = 1; v <= 4; v++) begin
            ins[0]       = 32'(v);
            ins_valid[0] = 1'b1;
            vectors++;
            if (ins_ready[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL fill_ready token %0d: got %b expected 1", v, ins_ready[0]);
            end
            step(0);
        end
        ins[0] = 32'h5;
        step(0);
        step(0);
        vectors++;
        if (ins_ready[0] !== 1'b0 || outs_valid[0] !== 1'b1 || outs[0] !== 32'h1) begin
            miscompares++;
            $display("FAIL fill_full_hold: got rdy=%b vld=%b data=%h expected rdy=0 vld=1 data=1",
                     ins_ready[0], outs_valid[0], outs[0]);
        end
        outs_ready[0] = 1'b1;
        for (int c = 0; c < 12 && got.size() < 5; c++) begin
            if (outs_valid[0] === 1'b1) got.push_back(outs[0]);
            step(0);
            if (last_wr) ins_valid[0] = 1'b0;
        end
        outs_ready[0] = 1'b0;
        ins_valid[0]  = 1'b0;
        vectors++;
        if (got.size() != 5) begin
            miscompares++;
            $display("FAIL fill_drain_count: got %0d tokens expected 5", got.size());
        end
        for (int i = 0; i < got.size(); i++) begin
            vectors++;
            if (got[i] !== 32'(i + 1)) begin
                miscompares++;
                $display("FAIL fill_order idx %0d: got %h expected %h", i, got[i], i + 1);
            end
        end
    endtask

    task automatic test_full_read();
        int n;
        do_reset();
        outs_ready[0] = 1'b0;
        ins_valid[0]  = 1'b1;
        for (int v = 0; v < 4; v++) begin
            ins[0] = 32'h10 + 32'(v);
            step(0);
        end
        ins[0]        = 32'h99;
        outs_ready[0] = 1'b1;
        vectors++;
        if (ins_ready[0] !== 1'b0 || outs[0] !== 32'h10) begin
            miscompares++;
            $display("FAIL full_read_pre: got rdy=%b data=%h expected rdy=0 data=10",
                     ins_ready[0], outs[0]);
        end
        step(0);
        ins_valid[0]  = 1'b0;
        outs_ready[0] = 1'b0;
        vectors++;
        if (ins_ready[0] !== 1'b1 || outs_valid[0] !== 1'b1 || outs[0] !== 32'h11) begin
            miscompares++;
            $display("FAIL full_read_post: got rdy=%b vld=%b data=%h expected rdy=1 vld=1 data=11",
                     ins_ready[0], outs_valid[0], outs[0]);
        end
        n = 0;
        outs_ready[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (outs_valid[0] === 1'b1) begin
                vectors++;
                if (outs[0] !== 32'h11 + 32'(n)) begin
                    miscompares++;
                    $display("FAIL full_read_order idx %0d: got %h expected %h", n, outs[0], 32'h11 + n);
                end
                n++;
            end
            step(0);
        end
        outs_ready[0] = 1'b0;
        vectors++;
        if (n != 3) begin
            miscompares++;
            $display("FAIL full_read_count: got %0d tokens expected 3", n);
        end
    endtask

    task automatic test_streaming();
        do_reset();
        outs_ready[1] = 1'b1;
        ins_valid[1]  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            ins[1] = 32'(i);
            step(1);
            vectors++;
            if (outs_valid[1] !== 1'b1 || outs[1] !== 32'(i) || ins_ready[1] !== 1'b1) begin
                miscompares++;
                $display("FAIL stream token %0d: got vld=%b data=%h rdy=%b expected vld=1 data=%h rdy=1",
                         i, outs_valid[1], outs[1], ins_ready[1], i);
            end
        end
        ins_valid[1] = 1'b0;
        step(1);
        outs_ready[1] = 1'b0;
        vectors++;
        if (outs_valid[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_drain: outs_valid got %b expected 0", outs_valid[1]);
        end
    endtask

    task automatic test_random(input int k);
        int sent;
        int recvd;
        int n;
        sent  = 0;
        recvd = 0;
        n     = ns_of(k);
        do_reset();
        ins[k] = $urandom;
        for (int cyc = 0; cyc < 8000 && recvd < 1000; cyc++) begin
            ins_valid[k]  = (sent < 1000) && ($urandom_range(0, 1) == 1);
            outs_ready[k] = ($urandom_range(0, 1) == 1);
            vectors++;
            if (ins_ready[k] !== (mq.size() != n)) begin
                miscompares++;
                $display("FAIL rand%0d_ready cyc %0d: got %b expected %b", n, cyc, ins_ready[k], mq.size() != n);
            end
            vectors++;
            if (outs_valid[k] !== (mq.size() != 0)) begin
                miscompares++;
                $display("FAIL rand%0d_valid cyc %0d: got %b expected %b", n, cyc, outs_valid[k], mq.size() != 0);
            end
            if (mq.size() != 0) begin
                vectors++;
                if (outs[k] !== mq[0]) begin
                    miscompares++;
                    $display("FAIL rand%0d_data cyc %0d: got %h expected %h", n, cyc, outs[k], mq[0]);
                end
            end
            step(k);
            if (last_wr) begin
                sent++;
                ins[k] = $urandom;
            end
            if (last_rd) recvd++;
        end
        ins_valid[k]  = 1'b0;
        outs_ready[k] = 1'b0;
        vectors++;
        if (recvd != 1000) begin
            miscompares++;
            $display("FAIL rand%0d_complete: got %0d tokens expected 1000", n, recvd);
        end
    endtask

    task automatic test_midrun_reset();
        do_reset();
        outs_ready[0] = 1'b0;
        ins_valid[0]  = 1'b1;
        for (int v = 1; v <= 3; v++) begin
            ins[0] = 32'h11 * 32'(v);
            step(0);
        end
        ins_valid[0] = 1'b0;
        vectors++;
        if (outs_valid[0] !== 1'b1 || outs[0] !== 32'h11) begin
            miscompares++;
            $display("FAIL midrst_pre: got vld=%b data=%h expected vld=1 data=11", outs_valid[0], outs[0]);
        end
        #3;
        rst = 1'b0;
        #1;
        mq.delete();
        vectors++;
        if (outs_valid[0] !== 1'b0 || ins_ready[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_async: got vld=%b rdy=%b expected vld=0 rdy=1", outs_valid[0], ins_ready[0]);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        vectors++;
        if (outs_valid[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_release: outs_valid got %b expected 0", outs_valid[0]);
        end
        ins[0]       = 32'h77;
        ins_valid[0] = 1'b1;
        step(0);
        ins_valid[0] = 1'b0;
        vectors++;
        if (outs_valid[0] !== 1'b1 || outs[0] !== 32'h77) begin
            miscompares++;
            $display("FAIL midrst_first: got vld=%b data=%h expected vld=1 data=77", outs_valid[0], outs[0]);
        end
        outs_ready[0] = 1'b1;
        step(0);
        outs_ready[0] = 1'b0;
        vectors++;
        if (outs_valid[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_only_one: outs_valid got %b expected 0", outs_valid[0]);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            ins[i]        = '0;
            ins_valid[i]  = 1'b0;
            outs_ready[i] = 1'b0;
        end
        test_reset();
        test_fill();
        test_full_read();
        test_streaming();
        test_random(2);
        test_random(3);
        test_random(4);
        test_midrun_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/elastic_fifo.md
ELASTIC_FIFO -- requirements
Module: elastic_fifo

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4, giving storage depth in tokens (legal: 2..1024, any integer, not only powers of two).
REQ-002 SHALL have parameter DATA_TYPE, default 32, giving token width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ins  input  DATA_TYPE  upstream token data.
REQ-006 SHALL have port ins_valid  input  1  upstream token present.
REQ-007 SHALL have port ins_ready  output  1  FIFO can accept a token this cycle.
REQ-008 SHALL have port outs  output  DATA_TYPE  head-of-queue data, consumed by the downstream merge.
REQ-009 SHALL have port outs_valid  output  1  head-of-queue valid.
REQ-010 SHALL have port outs_ready  input  1  downstream accepts the token.

Function
REQ-011 Write transfer SHALL occur on a cycle with ins_valid=1 and ins_ready=1; read transfer SHALL occur on a cycle with outs_valid=1 and outs_ready=1.
REQ-012 ins_ready SHALL equal (count != NUM_SLOTS), driven from registered state only; no combinational path outs_ready -> ins_ready.
REQ-013 outs_valid SHALL equal (count != 0), registered; no combinational path ins_valid -> outs_valid and no empty bypass.
REQ-014 outs SHALL present the slot at the read pointer, valid whenever outs_valid=1; value when outs_valid=0 is don't-care.
REQ-015 Latency SHALL be exactly 1 cycle: a token written at edge N is visible on outs/outs_valid after edge N.
REQ-016 Tokens SHALL leave in arrival order; no loss, no duplication.
REQ-017 Write and read pointers SHALL be ceil(log2(NUM_SLOTS))-bit counters wrapping from NUM_SLOTS-1 to 0.
REQ-018 count SHALL be ceil(log2(NUM_SLOTS+1)) bits; +1 on write only, -1 on read only, unchanged on simultaneous write and read.
REQ-019 Full (count=NUM_SLOTS) with outs_ready=1: read SHALL occur, write SHALL be refused that cycle (ins_ready=0); ins_ready rises the next cycle.
REQ-020 Empty with ins_valid=1: write SHALL occur, outs_valid=0 that cycle, 1 next cycle.
REQ-021 One-slot-occupied with simultaneous write and read: count SHALL stay 1 and outs SHALL show the new token next cycle.
REQ-022 Sustained throughput SHALL be one token per cycle when neither full nor empty.
REQ-023 Upstream SHALL keep ins stable while ins_valid=1 and ins_ready=0; the FIFO SHALL keep outs stable while outs_valid=1 and outs_ready=0.

Reset
REQ-024 rst=0 SHALL asynchronously clear write pointer, read pointer, and count to 0.
REQ-025 During and after reset: outs_valid=0, ins_ready=1; storage contents SHALL NOT be reset and are don't-care.
REQ-026 Reset asserted mid-operation SHALL discard all stored tokens; first token after release SHALL follow REQ-020.
REQ-027 Deassertion SHALL be applied synchronously to clk by the surrounding system; the block SHALL require no extra release logic.

Structure
REQ-028 No shared package SHALL be required; pointer widths SHALL be derived locally via $clog2.
REQ-029 Storage SHALL be one sub-module elastic_fifo_mem (1 write port, 1 asynchronous read port, NUM_SLOTS x DATA_TYPE, no reset), with control logic in elastic_fifo.

Verification
REQ-030 Reset: hold rst=0 with ins_valid=1 for 3 cycles -> outs_valid=0, ins_ready=1, no write; release, push 0xA5 -> outs=0xA5, outs_valid=1 one cycle later.
REQ-031 Fill: NUM_SLOTS=4, outs_ready=0, push 0x1..0x5 -> 0x1..0x4 accepted, ins_ready=0 after 4th, 0x5 held; set outs_ready=1 -> out order 0x1,0x2,0x3,0x4,0x5.
REQ-032 Full plus read: full, ins_valid=1, outs_ready=1 -> one read, no write that cycle, count=3, ins_ready=1 next cycle.
REQ-033 Streaming: NUM_SLOTS=3, ins_valid and outs_ready constant 1, 100 tokens 0..99 -> 1-cycle latency, one token per cycle, pointers wrap without loss.
REQ-034 Random: random ins_valid/outs_ready (50%) with 1000 tokens, NUM_SLOTS in {2,5,8} -> scoreboard in-order match, count never exceeds NUM_SLOTS, no underflow.
REQ-035 Mid-run reset: 3 tokens stored, pulse rst=0 for 1 cycle (asynchronous, off clock edge) -> outs_valid=0 immediately, next token 0x77 is first output.
